pc_fetch_unit: RTL and testbench

//  Instruction-fetch front end of SimpleCPU: holds the 8-bit program counter,

---
 rtl/pc_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// SimpleCPU instruction-fetch front end: PC register, imem request FSM,
// instruction hand-off to decode. Optional feature macro: PC_WRAP_HALT_EN.

// Modulo-2^W adder; the carry out of the top bit is dropped.
module pc_eight_bit_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// Two-input selector: sel_i=0 picks a_i, sel_i=1 picks b_i.
module pc_two_to_one_mux #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sel_i,
    output logic [W-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

module pc_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               br_valid,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
`ifdef PC_WRAP_HALT_EN
        ,
        HALT  = 2'd3
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;

    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  pc_nxt;

    pc_eight_bit_adder #(.W(ADDR_W)) u_inc (
        .a_i   (pc_q),
        .b_i   (ADDR_W'(1)),
        .sum_o (pc_inc)
    );

    pc_two_to_one_mux #(.W(ADDR_W)) u_sel (
        .a_i   (pc_inc),
        .b_i   (br_target),
        .sel_i (br_valid),
        .y_o   (pc_nxt)
    );

    // Next-state and datapath: a redirect outranks ack, ready and halt.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (br_valid) pc_d = pc_nxt;
            end
            FETCH: begin
                if (br_valid) begin
                    pc_d = pc_nxt;
                end else if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_nxt;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (br_valid) begin
                    pc_d    = pc_nxt;
                    state_d = FETCH;
                end else if (instr_ready) begin
`ifdef PC_WRAP_HALT_EN
                    state_d = (&instr_pc_q) ? HALT : FETCH;
`else
                    state_d = FETCH;
`endif
                end
            end
`ifdef PC_WRAP_HALT_EN
            HALT: state_d = HALT;
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == ISSUE);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

`ifdef PC_WRAP_HALT_EN
    assign halted = (state_q == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed vector bench for pc_fetch_unit.
// Table rows plus a short wrap/halt tail sequence.
module tb_pc_fetch_unit;

    logic       clk;
    logic       rst;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic       br_valid;
    logic [7:0] br_target;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       halted;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       ack;
        logic [7:0] rdata;
        logic       br;
        logic [7:0] tgt;
        logic       rdy;
        logic       e_req;
        logic [7:0] e_addr;
        logic       e_valid;
        logic [7:0] e_instr;
        logic [7:0] e_ipc;
        logic       e_halt;
    } vec_t;

    vec_t vecs[$];

    pc_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic r, input logic a, input logic [7:0] d,
        input logic b, input logic [7:0] t, input logic y,
        input logic eq, input logic [7:0] ea, input logic ev,
        input logic [7:0] ei, input logic [7:0] ep, input logic eh);
        vec_t v;
        v.rst = r; v.ack = a; v.rdata = d;
        v.br = b; v.tgt = t; v.rdy = y;
        v.e_req = eq; v.e_addr = ea; v.e_valid = ev;
        v.e_instr = ei; v.e_ipc = ep; v.e_halt = eh;
        return v;
    endfunction

    task automatic chk(input string nm, input int row,
                       input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL row%0d %s: got %h want %h", row, nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int row);
        @(negedge clk);
        rst         = v.rst;
        imem_ack    = v.ack;
        imem_rdata  = v.rdata;
        br_valid    = v.br;
        br_target   = v.tgt;
        instr_ready = v.rdy;
        @(posedge clk);
        #1;
        chk("req",   row, {7'd0, imem_req},    {7'd0, v.e_req});
        chk("addr",  row, imem_addr,           v.e_addr);
        chk("valid", row, {7'd0, instr_valid}, {7'd0, v.e_valid});
        chk("instr", row, instr,               v.e_instr);
        chk("ipc",   row, instr_pc,            v.e_ipc);
        chk("halt",  row, {7'd0, halted},      {7'd0, v.e_halt});
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 8'h00;
        br_valid = 1'b0; br_target = 8'h00; instr_ready = 1'b0;

        //            rst ack rdata br tgt   rdy  req addr  v instr ipc  h
        // reset, then streaming with ack=1 ready=1
        vecs.push_back(mk(1,1,8'h00,0,8'h00,1, 0,8'h00,0,8'h00,8'h00,0));
        vecs.push_back(mk(0,1,8'h00,0,8'h00,1, 1,8'h00,0,8'h00,8'h00,0));
        vecs.push_back(mk(0,1,8'h00,0,8'h00,1, 0,8'h01,1,8'h00,8'h00,0));
        vecs.push_back(mk(0,1,8'h01,0,8'h00,1, 1,8'h01,0,8'h00,8'h00,0));
        vecs.push_back(mk(0,1,8'h01,0,8'h00,1, 0,8'h02,1,8'h01,8'h01,0));
        vecs.push_back(mk(0,1,8'h02,0,8'h00,1, 1,8'h02,0,8'h01,8'h01,0));
        vecs.push_back(mk(0,1,8'h02,0,8'h00,1, 0,8'h03,1,8'h02,8'h02,0));
        vecs.push_back(mk(0,1,8'h03,0,8'h00,1, 1,8'h03,0,8'h02,8'h02,0));
        vecs.push_back(mk(0,1,8'h03,0,8'h00,0, 0,8'h04,1,8'h03,8'h03,0));
        // decode stalls 5 cycles holding instr from 03
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,1,8'h77,0,8'h00,0, 0,8'h04,1,8'h03,8'h03,0));
        vecs.push_back(mk(0,1,8'h04,0,8'h00,1, 1,8'h04,0,8'h03,8'h03,0));
        vecs.push_back(mk(0,1,8'h04,0,8'h00,1, 0,8'h05,1,8'h04,8'h04,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,1, 1,8'h05,0,8'h04,8'h04,0));
        // ack delayed 3 cycles at 05
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,8'h00,0,8'h00,1, 1,8'h05,0,8'h04,8'h04,0));
        vecs.push_back(mk(0,1,8'h05,0,8'h00,1, 0,8'h06,1,8'h05,8'h05,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,1, 1,8'h06,0,8'h05,8'h05,0));
        // branch with ack in FETCH: word dropped
        vecs.push_back(mk(0,1,8'h06,1,8'h10,1, 1,8'h10,0,8'h05,8'h05,0));
        vecs.push_back(mk(0,1,8'hAA,1,8'h40,1, 1,8'h40,0,8'h05,8'h05,0));
        vecs.push_back(mk(0,1,8'h40,0,8'h00,0, 0,8'h41,1,8'h40,8'h40,0));
        // branch in ISSUE, not ready: squash
        vecs.push_back(mk(0,0,8'h00,1,8'h20,0, 1,8'h20,0,8'h40,8'h40,0));
        vecs.push_back(mk(0,1,8'h20,0,8'h00,0, 0,8'h21,1,8'h20,8'h20,0));
        // branch with transfer in same cycle
        vecs.push_back(mk(0,0,8'h00,1,8'h30,1, 1,8'h30,0,8'h20,8'h20,0));
        vecs.push_back(mk(0,0,8'h00,0,8'h00,1, 1,8'h30,0,8'h20,8'h20,0));
        // reset in FETCH with req pending
        vecs.push_back(mk(1,1,8'h55,0,8'h00,1, 0,8'h00,0,8'h00,8'h00,0));
        vecs.push_back(mk(0,1,8'h00,0,8'h00,0, 1,8'h00,0,8'h00,8'h00,0));
        vecs.push_back(mk(0,1,8'h9C,0,8'h00,0, 0,8'h01,1,8'h9C,8'h00,0));
        // reset in ISSUE
        vecs.push_back(mk(1,0,8'h00,0,8'h00,0, 0,8'h00,0,8'h00,8'h00,0));
        // branch in IDLE to FE, then run to FF
        vecs.push_back(mk(0,1,8'h00,1,8'hFE,1, 1,8'hFE,0,8'h00,8'h00,0));
        vecs.push_back(mk(0,1,8'hFE,0,8'h00,1, 0,8'hFF,1,8'hFE,8'hFE,0));
        vecs.push_back(mk(0,1,8'hFF,0,8'h00,1, 1,8'hFF,0,8'hFE,8'hFE,0));
        vecs.push_back(mk(0,1,8'hFF,0,8'h00,0, 0,8'h00,1,8'hFF,8'hFF,0));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        // transfer of the word fetched from FF
`ifdef PC_WRAP_HALT_EN
        apply(mk(0,1,8'h00,0,8'h00,1, 0,8'h00,0,8'hFF,8'hFF,1), 100);
        apply(mk(0,1,8'h00,1,8'h50,1, 0,8'h00,0,8'hFF,8'hFF,1), 101);
        apply(mk(0,1,8'h00,0,8'h00,1, 0,8'h00,0,8'hFF,8'hFF,1), 102);
        apply(mk(1,0,8'h00,0,8'h00,1, 0,8'h00,0,8'h00,8'h00,0), 103);
        apply(mk(0,0,8'h00,0,8'h00,1, 1,8'h00,0,8'h00,8'h00,0), 104);
`else
        apply(mk(0,1,8'h00,0,8'h00,1, 1,8'h00,0,8'hFF,8'hFF,0), 100);
        apply(mk(0,1,8'h00,0,8'h00,1, 0,8'h01,1,8'h00,8'h00,0), 101);
        apply(mk(0,1,8'h00,1,8'h50,1, 1,8'h50,0,8'h00,8'h00,0), 102);
        apply(mk(0,1,8'h50,0,8'h00,1, 0,8'h51,1,8'h50,8'h50,0), 103);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
